// File: rtl/gate_ctrl_if.sv
// rtl/gate_ctrl_if.sv - handshake/bus bundle between gate_ctrl and its counter/display neighbours
// Signals:
//   run         level, keep measuring while high
//   cnt_in      BCD digits from the cascaded counters, digit 0 in [3:0]
//   ovf_in      carry of the most-significant digit counter (counter clock domain)
//   gate_en     counter enable
//   cnt_clear_n counter clear, active low
//   latch       one-cycle strobe, result/ovf valid from this cycle
//   result      captured digits
//   ovf         captured overflow flag
//   busy        high whenever a measurement is in progress
// master: the environment driving run/cnt_in/ovf_in; slave: gate_ctrl.
interface gate_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  run;
    logic [4*DIGITS-1:0]   cnt_in;
    logic                  ovf_in;
    logic                  gate_en;
    logic                  cnt_clear_n;
    logic                  latch;
    logic [4*DIGITS-1:0]   result;
    logic                  ovf;
    logic                  busy;

    modport master (
        output run, cnt_in, ovf_in,
        input  gate_en, cnt_clear_n, latch, result, ovf, busy
    );

    modport slave (
        input  run, cnt_in, ovf_in,
        output gate_en, cnt_clear_n, latch, result, ovf, busy
    );
endinterface

// File: rtl/gate_ctrl.sv
// rtl/gate_ctrl.sv - gate-window sequencer for the frequency-count path
// Opens a GATE_CYCLES counting gate on the reference clock, waits SETTLE_CYCLES,
// then captures the BCD digits (and overflow) into a held result register.
// Repeats while run is high. All outputs are registered.
// Ports:
//   clk      reference time base, posedge
//   clear_n  asynchronous active-low reset
//   bus      gate_ctrl_if.slave (run, cnt_in, ovf_in in; gate_en, cnt_clear_n,
//            latch, result, ovf, busy out)
// Optional: OVF_DETECT_EN builds the ovf_in synchronizer and overflow capture;
// without it ovf is constant 0 and ovf_in is ignored.
module gate_ctrl #(
    parameter int DIGITS        = 4,
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CLEAR_CYCLES  = 2,
    parameter int CNT_W         = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    gate_ctrl_if.slave   bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_en_q, gate_en_d;
    logic             cnt_clear_n_q, cnt_clear_n_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     result_q, result_d;

    // The counter is loaded with (length - 1) on entry to a timed state and the
    // state is left on the cycle it reads zero, giving exactly 'length' cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - ONE;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.run) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LOAD;
                end
            end
            S_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = S_GATE;
                    cnt_d   = GATE_LOAD;
                end
            end
            S_GATE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                cnt_d   = CLEAR_LOAD;
                state_d = bus.run ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop that
    // lines up with the state register. The digits are captured on the edge
    // entering LATCH, so result is already valid while the strobe is high.
    always_comb begin
        gate_en_d     = (state_d == S_GATE);
        cnt_clear_n_d = (state_d == S_GATE) || (state_d == S_SETTLE) || (state_d == S_LATCH);
        latch_d       = (state_d == S_LATCH);
        busy_d        = (state_d != S_IDLE);
        result_d      = latch_d ? bus.cnt_in : result_q;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            gate_en_q     <= 1'b0;
            cnt_clear_n_q <= 1'b0;
            latch_q       <= 1'b0;
            busy_q        <= 1'b0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gate_en_q     <= gate_en_d;
            cnt_clear_n_q <= cnt_clear_n_d;
            latch_q       <= latch_d;
            busy_q        <= busy_d;
            result_q      <= result_d;
        end
    end

    assign bus.gate_en     = gate_en_q;
    assign bus.cnt_clear_n = cnt_clear_n_q;
    assign bus.latch       = latch_q;
    assign bus.busy        = busy_q;
    assign bus.result      = result_q;

`ifdef OVF_DETECT_EN
    // ovf_sync_q[0..1] is the two-flop synchronizer; [2] holds the previous
    // synchronized value for edge detection. A falling edge of the top-digit
    // carry marks the counter wrapping 9 -> 0, i.e. it overflowed.
    logic [2:0] ovf_sync_q, ovf_sync_d;
    logic       ovf_fall;
    logic       pend_q, pend_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        ovf_sync_d = {ovf_sync_q[1:0], bus.ovf_in};
        ovf_fall   = ovf_sync_q[2] & ~ovf_sync_q[1];
        pend_d     = pend_q;
        if (state_q == S_CLEAR) begin
            pend_d = 1'b0;
        end else if (((state_q == S_GATE) || (state_q == S_SETTLE)) && ovf_fall) begin
            pend_d = 1'b1;
        end
        // pend_d, not pend_q, so an edge seen in the last SETTLE cycle still counts
        ovf_d = latch_d ? pend_d : ovf_q;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ovf_sync_q <= '0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_sync_q <= ovf_sync_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gate_ctrl.sv
// tb/tb_gate_ctrl.sv - self-checking bench for gate_ctrl
module tb_gate_ctrl;
    localparam int DIG = 4;
    localparam int C   = 2;
    localparam int G   = 20;
    localparam int S   = 4;
    localparam int P   = C + G + S + 1;
`ifdef OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk     = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    gate_ctrl_if #(.DIGITS(DIG)) bus0 ();
    gate_ctrl_if #(.DIGITS(DIG)) bus1 ();

    gate_ctrl #(.DIGITS(DIG), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
                .CLEAR_CYCLES(C), .CNT_W(16)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus0)
    );

    gate_ctrl #(.DIGITS(DIG), .GATE_CYCLES(1), .SETTLE_CYCLES(1),
                .CLEAR_CYCLES(1), .CNT_W(16)) dut1 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a measurement is a timeline of P cycles indexed by
    // m_pos (clear, then gate, then settle, then the latch cycle). ovf_in is
    // seen through a two-cycle delay; m_hist[0] is the newest sample.
    bit          m_active;
    int          m_pos;
    bit          m_pend;
    bit          m_fall;
    logic [15:0] m_result;
    bit          m_ovf;
    bit   [2:0]  m_hist;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_pend   = 1'b0;
            m_result = '0;
            m_ovf    = 1'b0;
            m_hist   = '0;
        end else begin
            m_fall = m_hist[2] && !m_hist[1];
            if (m_active && m_pos < C) m_pend = 1'b0;
            else if (m_active && m_pos < C + G + S && m_fall) m_pend = 1'b1;
            if (!m_active) begin
                if (bus0.run) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == P - 1) begin
                if (bus0.run) m_pos = 0;
                else m_active = 1'b0;
            end else begin
                m_pos++;
            end
            if (m_active && m_pos == P - 1) begin
                m_result = bus0.cnt_in;
                m_ovf    = OVF_ON && m_pend;
            end
            m_hist = {m_hist[1:0], bus0.ovf_in};
        end
    end

    task automatic check_model(input string tag);
        chk({tag, ".gate_en"},     32'(bus0.gate_en),     32'(m_active && m_pos >= C && m_pos < C + G));
        chk({tag, ".cnt_clear_n"}, 32'(bus0.cnt_clear_n), 32'(m_active && m_pos >= C));
        chk({tag, ".latch"},       32'(bus0.latch),       32'(m_active && m_pos == P - 1));
        chk({tag, ".busy"},        32'(bus0.busy),        32'(m_active));
        chk({tag, ".result"},      32'(bus0.result),      32'(m_result));
        chk({tag, ".ovf"},         32'(bus0.ovf),         32'(m_ovf));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".gate_en"},     32'(bus0.gate_en),     32'd0);
        chk({tag, ".cnt_clear_n"}, 32'(bus0.cnt_clear_n), 32'd0);
        chk({tag, ".latch"},       32'(bus0.latch),       32'd0);
        chk({tag, ".result"},      32'(bus0.result),      32'd0);
        chk({tag, ".ovf"},         32'(bus0.ovf),         32'd0);
        chk({tag, ".busy"},        32'(bus0.busy),        32'd0);
    endtask

    task automatic wait_latch0(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * P && !found; i++) begin
            tick();
            if (bus0.latch) found = 1'b1;
        end
        chk({tag, ".latch_seen"}, 32'(found), 32'd1);
    endtask

    typedef struct {
        bit          run;
        logic [15:0] cnt;
        int          n;
        bit          gate;
        bit          clrn;
        bit          lat;
        bit          busy;
        logic [15:0] res;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // run, cnt_in, cycles, gate_en, cnt_clear_n, latch, busy, result
        tbl[0] = '{1'b1, 16'h1234, C,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[1] = '{1'b1, 16'h1234, G,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[2] = '{1'b1, 16'h1234, S,  1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 16'h1234, 1,  1'b0, 1'b1, 1'b1, 1'b1, 16'h1234};
        tbl[4] = '{1'b1, 16'h9999, C,  1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[5] = '{1'b1, 16'h9999, 4,  1'b1, 1'b1, 1'b0, 1'b1, 16'h1234};
        tbl[6] = '{1'b0, 16'h9999, 16, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234};
        tbl[7] = '{1'b0, 16'h9999, S,  1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
        tbl[8] = '{1'b0, 16'h9999, 1,  1'b0, 1'b1, 1'b1, 1'b1, 16'h9999};
        tbl[9] = '{1'b0, 16'h9999, 3,  1'b0, 1'b0, 1'b0, 1'b0, 16'h9999};

        bus0.run = 1'b0; bus0.cnt_in = '0; bus0.ovf_in = 1'b0;
        bus1.run = 1'b0; bus1.cnt_in = 16'h0042; bus1.ovf_in = 1'b0;

        #1;
        check_reset_outputs("por");
        #22 clear_n = 1'b1;
        tick();
        check_model("idle");

        // Directed timeline: full measurement, held result, run drop in GATE.
        for (int r = 0; r < 10; r++) begin
            bus0.run    = tbl[r].run;
            bus0.cnt_in = tbl[r].cnt;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick();
                chk($sformatf("vec%0d.%0d.gate_en", r, k),     32'(bus0.gate_en),     32'(tbl[r].gate));
                chk($sformatf("vec%0d.%0d.cnt_clear_n", r, k), 32'(bus0.cnt_clear_n), 32'(tbl[r].clrn));
                chk($sformatf("vec%0d.%0d.latch", r, k),       32'(bus0.latch),       32'(tbl[r].lat));
                chk($sformatf("vec%0d.%0d.busy", r, k),        32'(bus0.busy),        32'(tbl[r].busy));
                chk($sformatf("vec%0d.%0d.result", r, k),      32'(bus0.result),      32'(tbl[r].res));
            end
        end

        // Overflow: pulse ovf_in early in GATE, then a clean measurement.
        bus0.run = 1'b1; bus0.cnt_in = 16'h0007;
        repeat (C + 1) tick();
        chk("ovf.in_gate", 32'(bus0.gate_en), 32'd1);
        bus0.ovf_in = 1'b1;
        repeat (3) tick();
        bus0.ovf_in = 1'b0;
        wait_latch0("ovf1");
        chk("ovf1.ovf", 32'(bus0.ovf), 32'(OVF_ON));
        wait_latch0("ovf0");
        chk("ovf0.ovf", 32'(bus0.ovf), 32'd0);
        bus0.run = 1'b0;
        repeat (P + 2) tick();
        check_model("ovf.idle");

        // Minimum lengths on the second instance: period 4, 1-cycle gate.
        begin
            bit found;
            found = 1'b0;
            bus1.run = 1'b1;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (bus1.latch) found = 1'b1;
            end
            chk("min.latch_seen", 32'(found), 32'd1);
            chk("min.result", 32'(bus1.result), 32'h0042);
            for (int k = 1; k <= 12; k++) begin
                tick();
                chk($sformatf("min.%0d.latch", k),       32'(bus1.latch),       32'(k % 4 == 0));
                chk($sformatf("min.%0d.gate_en", k),     32'(bus1.gate_en),     32'(k % 4 == 2));
                chk($sformatf("min.%0d.cnt_clear_n", k), 32'(bus1.cnt_clear_n), 32'(k % 4 != 1));
                chk($sformatf("min.%0d.busy", k),        32'(bus1.busy),        32'd1);
            end
            bus1.run = 1'b0;
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 19) == 0) bus0.run = ~bus0.run;
            bus0.cnt_in = 16'($urandom);
            bus0.ovf_in = ($urandom_range(0, 3) == 0);
            tick();
            check_model("rnd");
        end

        // Asynchronous reset in the middle of a gate window.
        begin
            bit found;
            found = 1'b0;
            bus0.run = 1'b1;
            for (int i = 0; i < 4 * P && !found; i++) begin
                tick();
                if (bus0.gate_en) found = 1'b1;
            end
            chk("rst.gate_seen", 32'(found), 32'd1);
            #2 clear_n = 1'b0;
            #1;
            check_reset_outputs("rst");
            tick();
            check_reset_outputs("rst.hold");
            #2 clear_n = 1'b1;
        end

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) bus0.run = ~bus0.run;
            bus0.cnt_in = 16'($urandom);
            bus0.ovf_in = ($urandom_range(0, 3) == 0);
            tick();
            check_model("rnd2");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
